uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_parser.sv | 217 +++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: hunts for a header byte in the UART byte stream, buffers a
// length-prefixed payload, verifies its 8-bit additive checksum and replays the
// payload on a ready/valid byte stream with a last marker.
`timescale 1ns/1ps
module uart_frame_parser #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       drop
);

  localparam int unsigned IDX_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC);

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] len, len_n;
  logic [IDX_W-1:0] wr_idx, wr_idx_n;
  logic [IDX_W-1:0] rd_idx, rd_idx_n;
  logic [IDX_W-1:0] rd_next;
  logic [7:0]       sum, sum_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic             m_valid_n, m_last_n;
  logic [7:0]       m_data_n;
  logic             frame_ok_n, frame_err_n, drop_n;
  logic [1:0]       err_code_n;
  logic             buf_we;
  logic             expired;

  logic [7:0]       mem [MAX_LEN];

  assign rd_next = rd_idx + IDX_ONE;
  // Inter-byte gap has run out and no byte arrived to rescue the frame
  assign expired = (timer == TMR_LAST) && !rx_valid;

  // Payload buffer, written one byte per accepted payload strobe
  always_ff @(posedge clk) begin
    if (buf_we) begin
      mem[BUF_AW'(wr_idx)] <= rx_data;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      sum       <= '0;
      timer     <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
      drop      <= 1'b0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      wr_idx    <= wr_idx_n;
      rd_idx    <= rd_idx_n;
      sum       <= sum_n;
      timer     <= timer_n;
      m_valid   <= m_valid_n;
      m_data    <= m_data_n;
      m_last    <= m_last_n;
      frame_ok  <= frame_ok_n;
      frame_err <= frame_err_n;
      err_code  <= err_code_n;
      drop      <= drop_n;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_n     = state;
    len_n       = len;
    wr_idx_n    = wr_idx;
    rd_idx_n    = rd_idx;
    sum_n       = sum;
    timer_n     = '0;
    m_valid_n   = m_valid;
    m_data_n    = m_data;
    m_last_n    = m_last;
    frame_ok_n  = 1'b0;
    frame_err_n = 1'b0;
    err_code_n  = err_code;
    drop_n      = 1'b0;
    buf_we      = 1'b0;

    // The gap timer only runs while a frame is being collected
    if (state == S_LEN || state == S_PAYLOAD || state == S_CHK) begin
      timer_n = rx_valid ? '0 : timer + TMR_W'(1);
    end

    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == HEADER) begin
          state_n = S_LEN;
        end
      end

      S_LEN: begin
        if (rx_valid) begin
          if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
            frame_err_n = 1'b1;
            err_code_n  = ERR_LEN;
            state_n     = S_IDLE;
          end else begin
            len_n    = IDX_W'(rx_data);
            sum_n    = rx_data;
            wr_idx_n = '0;
            state_n  = S_PAYLOAD;
          end
        end else if (expired) begin
          frame_err_n = 1'b1;
          err_code_n  = ERR_TMO;
          timer_n     = '0;
          state_n     = S_IDLE;
        end
      end

      S_PAYLOAD: begin
        if (rx_valid) begin
          buf_we   = 1'b1;
          sum_n    = sum + rx_data;
          wr_idx_n = wr_idx + IDX_ONE;
          if (wr_idx == len - IDX_ONE) begin
            state_n = S_CHK;
          end
        end else if (expired) begin
          frame_err_n = 1'b1;
          err_code_n  = ERR_TMO;
          timer_n     = '0;
          state_n     = S_IDLE;
        end
      end

      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == sum) begin
            frame_ok_n = 1'b1;
            rd_idx_n   = '0;
            m_valid_n  = 1'b1;
            m_data_n   = mem['0];
            m_last_n   = (len == IDX_ONE);
            state_n    = S_DRAIN;
          end else begin
            frame_err_n = 1'b1;
            err_code_n  = ERR_CHK;
            state_n     = S_IDLE;
          end
        end else if (expired) begin
          frame_err_n = 1'b1;
          err_code_n  = ERR_TMO;
          timer_n     = '0;
          state_n     = S_IDLE;
        end
      end

      S_DRAIN: begin
        // The receiver cannot be stalled, so anything arriving now is lost
        if (rx_valid) begin
          drop_n = 1'b1;
        end
        if (m_valid && m_ready) begin
          if (m_last) begin
            m_valid_n = 1'b0;
            m_last_n  = 1'b0;
            m_data_n  = '0;
            rd_idx_n  = '0;
            state_n   = S_IDLE;
          end else begin
            rd_idx_n = rd_next;
            m_data_n = mem[BUF_AW'(rd_next)];
            m_last_n = (rd_next == len - IDX_ONE);
          end
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: scenario tasks drive byte strobes; expected
// payload beats go to a scoreboard queue and are checked as they stream out.
`timescale 1ns/1ps
module tb_uart_frame_parser;

  localparam int unsigned TB_TMO = 40;
  localparam logic [7:0]  HDR    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       drop;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int drop_cnt = 0;
  int ok_cyc = -1;
  int err_cyc = -1;
  int last_edge = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_beat;
  int         beat_cyc[$];
  logic [7:0] tx_q[$];
  logic [7:0] pl[$];

  uart_frame_parser #(
    .HEADER     (HDR),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(TB_TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every transfer pops one expected beat; pulses are tallied
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        beat_cyc.push_back(cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_beat: got data=%02h last=%0b, expected no beat", m_data, m_last);
        end else begin
          exp_beat = exp_q.pop_front();
          if ({m_last, m_data} !== exp_beat) begin
            n_bad++;
            $display("FAIL sb_beat: got data=%02h last=%0b, expected data=%02h last=%0b",
                     m_data, m_last, exp_beat[7:0], exp_beat[8]);
          end
        end
      end
      if (frame_ok) begin
        ok_cnt++;
        ok_cyc = cyc;
      end
      if (frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (drop) drop_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    last_edge = cyc;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
  endtask

  task automatic send_seq();
    foreach (tx_q[i]) send_byte(tx_q[i]);
    tx_q.delete();
  endtask

  // Frame from pl into tx_q; optionally register its beats as expected output
  task automatic build_frame(input bit good, input bit expect_out);
    logic [7:0] s;
    s = 8'(pl.size());
    tx_q.push_back(HDR);
    tx_q.push_back(s);
    foreach (pl[i]) begin
      tx_q.push_back(pl[i]);
      s += pl[i];
      if (expect_out) exp_q.push_back({1'(i == pl.size() - 1), pl[i]});
    end
    tx_q.push_back(good ? s : 8'h00);
    pl.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({m_valid, m_data, m_last, frame_ok, frame_err, drop} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %04h expected 0000",
               {m_valid, m_data, m_last, frame_ok, frame_err, drop});
    end
    n_cmp++;
    if (err_code !== 2'b00) begin
      n_bad++; $display("FAIL reset_err_code: got %0b expected 00", err_code);
    end
    rst_n = 1'b1;
    idle(2);
    n_cmp++;
    if ({m_valid, m_data, m_last, frame_ok, frame_err, drop} !== 13'h0) begin
      n_bad++;
      $display("FAIL post_reset_outputs: got %04h expected 0000",
               {m_valid, m_data, m_last, frame_ok, frame_err, drop});
    end
  endtask

  task automatic test_good();
    int ok0, err0, e;
    ok0 = ok_cnt; err0 = err_cnt;
    m_ready = 1'b1;
    beat_cyc.delete();
    tx_q = '{HDR, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    send_seq();
    e = last_edge;
    idle(10);
    n_cmp++;
    if (ok_cnt - ok0 !== 1) begin
      n_bad++; $display("FAIL good_ok_count: got %0d expected 1", ok_cnt - ok0);
    end
    n_cmp++;
    if (ok_cyc !== e) begin
      n_bad++; $display("FAIL good_ok_cycle: got %0d expected %0d", ok_cyc, e);
    end
    n_cmp++;
    if (beat_cyc.size() !== 3) begin
      n_bad++; $display("FAIL good_beat_count: got %0d expected 3", beat_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (beat_cyc[i] !== e + i) begin
          n_bad++; $display("FAIL good_beat_cycle[%0d]: got %0d expected %0d", i, beat_cyc[i], e + i);
        end
      end
    end
    n_cmp++;
    if (err_cnt - err0 !== 0 || err_code !== 2'b00) begin
      n_bad++; $display("FAIL good_no_err: got errs=%0d code=%0b expected errs=0 code=00",
                        err_cnt - err0, err_code);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++; $display("FAIL good_outstanding: got %0d beats left expected 0", exp_q.size());
    end
  endtask

  task automatic test_bad_chk();
    int ok0, err0;
    ok0 = ok_cnt; err0 = err_cnt;
    beat_cyc.delete();
    tx_q = '{HDR, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    send_seq();
    idle(1);
    n_cmp++;
    if (err_cnt - err0 !== 1 || err_cyc !== last_edge) begin
      n_bad++; $display("FAIL chk_err_pulse: got count=%0d cyc=%0d expected count=1 cyc=%0d",
                        err_cnt - err0, err_cyc, last_edge);
    end
    n_cmp++;
    if (err_code !== 2'b10) begin
      n_bad++; $display("FAIL chk_err_code: got %0b expected 10", err_code);
    end
    idle(5);
    n_cmp++;
    if (beat_cyc.size() !== 0 || ok_cnt !== ok0) begin
      n_bad++; $display("FAIL chk_no_output: got beats=%0d oks=%0d expected 0 0",
                        beat_cyc.size(), ok_cnt - ok0);
    end
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_frame(1'b1, 1'b1);
    send_seq();
    idle(12);
    n_cmp++;
    if (ok_cnt - ok0 !== 1 || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL chk_recover: got oks=%0d left=%0d expected 1 0",
                        ok_cnt - ok0, exp_q.size());
    end
  endtask

  task automatic test_bad_len();
    int ok0, err0;
    ok0 = ok_cnt; err0 = err_cnt;
    tx_q = '{HDR, 8'h00};
    send_seq();
    idle(2);
    n_cmp++;
    if (err_cnt - err0 !== 1 || err_code !== 2'b01) begin
      n_bad++; $display("FAIL len_zero: got errs=%0d code=%0b expected 1 01", err_cnt - err0, err_code);
    end
    tx_q = '{HDR, 8'h11};
    send_seq();
    idle(2);
    n_cmp++;
    if (err_cnt - err0 !== 2 || err_code !== 2'b01) begin
      n_bad++; $display("FAIL len_over: got errs=%0d code=%0b expected 2 01", err_cnt - err0, err_code);
    end
    // Maximum-length frame straight after, with a header byte inside the payload
    pl.push_back(HDR);
    for (int i = 1; i < 16; i++) pl.push_back(8'($urandom_range(0, 255)));
    build_frame(1'b1, 1'b1);
    send_seq();
    idle(25);
    n_cmp++;
    if (ok_cnt - ok0 !== 1 || exp_q.size() !== 0 || err_cnt - err0 !== 2) begin
      n_bad++; $display("FAIL len_max_frame: got oks=%0d left=%0d errs=%0d expected 1 0 2",
                        ok_cnt - ok0, exp_q.size(), err_cnt - err0);
    end
  endtask

  task automatic test_timeout();
    int ok0, err0, e0;
    ok0 = ok_cnt; err0 = err_cnt;
    tx_q = '{HDR, 8'h02, 8'h11};
    send_seq();
    e0 = last_edge;
    idle(TB_TMO + 5);
    n_cmp++;
    if (err_cnt - err0 !== 1 || err_cyc !== e0 + TB_TMO) begin
      n_bad++; $display("FAIL tmo_pulse: got count=%0d cyc=%0d expected count=1 cyc=%0d",
                        err_cnt - err0, err_cyc, e0 + TB_TMO);
    end
    n_cmp++;
    if (err_code !== 2'b11) begin
      n_bad++; $display("FAIL tmo_code: got %0b expected 11", err_code);
    end
    // Bytes landing exactly on the expiry cycle keep the frame alive
    err0 = err_cnt;
    pl = '{8'h11, 8'h22};
    build_frame(1'b1, 1'b1);
    send_byte(tx_q.pop_front());
    send_byte(tx_q.pop_front());
    send_byte(tx_q.pop_front());
    while (tx_q.size() != 0) begin
      idle(TB_TMO - 1);
      send_byte(tx_q.pop_front());
    end
    idle(8);
    n_cmp++;
    if (err_cnt - err0 !== 0 || ok_cnt - ok0 !== 1) begin
      n_bad++; $display("FAIL tmo_rescue: got errs=%0d oks=%0d expected 0 1", err_cnt - err0, ok_cnt - ok0);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++; $display("FAIL tmo_rescue_beats: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_stall_drop();
    int ok0, err0, drop0;
    logic [7:0] pd;
    logic plast, stalled;
    ok0 = ok_cnt; err0 = err_cnt; drop0 = drop_cnt;
    m_ready = 1'b0;
    pl = '{8'h01, 8'h80, 8'hFF, 8'h7E, 8'h33};
    build_frame(1'b1, 1'b1);
    send_seq();
    stalled = 1'b0; pd = 8'h00; plast = 1'b0;
    for (int i = 0; i < 60 && m_valid; i++) begin
      if (stalled) begin
        n_cmp++;
        if ({m_last, m_data} !== {plast, pd}) begin
          n_bad++; $display("FAIL stall_hold: got data=%02h last=%0b expected data=%02h last=%0b",
                            m_data, m_last, pd, plast);
        end
      end
      m_ready = i[0];
      stalled = !m_ready;
      pd = m_data;
      plast = m_last;
      if (i == 3) begin
        rx_valid = 1'b1;
        rx_data  = HDR;
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_drain_end: got m_valid=%0b expected 0", m_valid);
    end
    // Header on the very first cycle back in idle
    m_ready = 1'b1;
    pl = '{8'h10, 8'h20};
    build_frame(1'b1, 1'b1);
    send_seq();
    idle(10);
    n_cmp++;
    if (drop_cnt - drop0 !== 1) begin
      n_bad++; $display("FAIL stall_drop: got %0d expected 1", drop_cnt - drop0);
    end
    n_cmp++;
    if (ok_cnt - ok0 !== 2 || err_cnt - err0 !== 0 || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL stall_frames: got oks=%0d errs=%0d left=%0d expected 2 0 0",
                        ok_cnt - ok0, err_cnt - err0, exp_q.size());
    end
  endtask

  task automatic test_noise();
    int ok0, err0, drop0;
    ok0 = ok_cnt; err0 = err_cnt; drop0 = drop_cnt;
    tx_q = '{8'h00, 8'hFF, 8'h5A};
    send_seq();
    pl = '{8'hC3};
    build_frame(1'b1, 1'b1);
    send_seq();
    idle(8);
    n_cmp++;
    if (ok_cnt - ok0 !== 1 || err_cnt - err0 !== 0 || drop_cnt - drop0 !== 0) begin
      n_bad++; $display("FAIL noise_ignored: got oks=%0d errs=%0d drops=%0d expected 1 0 0",
                        ok_cnt - ok0, err_cnt - err0, drop_cnt - drop0);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++; $display("FAIL noise_beats: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int ok0, err0;
    ok0 = ok_cnt; err0 = err_cnt;
    m_ready = 1'b1;
    tx_q = '{HDR, 8'h04, 8'h01, 8'h02};
    send_seq();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, m_data, m_last, frame_ok, frame_err, drop, err_code} !== 15'h0) begin
      n_bad++; $display("FAIL rst_mid_payload: got %04h expected 0000",
                        {m_valid, m_data, m_last, frame_ok, frame_err, drop, err_code});
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    m_ready = 1'b0;
    pl = '{8'h44, 8'h55};
    build_frame(1'b1, 1'b0);
    send_seq();
    idle(1);
    n_cmp++;
    if (m_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre_drain: got m_valid=%0b expected 1", m_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, m_data, m_last, frame_ok, frame_err, drop} !== 13'h0) begin
      n_bad++; $display("FAIL rst_mid_drain: got %04h expected 0000",
                        {m_valid, m_data, m_last, frame_ok, frame_err, drop});
    end
    idle(2);
    rst_n = 1'b1;
    m_ready = 1'b1;
    idle(2);
    pl = '{8'h0F, 8'hF0, 8'h3C};
    build_frame(1'b1, 1'b1);
    send_seq();
    idle(10);
    n_cmp++;
    if (ok_cnt - ok0 !== 2 || err_cnt - err0 !== 0 || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL rst_recover: got oks=%0d errs=%0d left=%0d expected 2 0 0",
                        ok_cnt - ok0, err_cnt - err0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_chk();
    test_bad_len();
    test_timeout();
    test_stall_drop();
    test_noise();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
